// File: rtl/controle_de_reproducao.sv
// Playback sequencer for the four music blocks.
// Debounces the front-panel button, advances the song selection on a press
// or on end-of-song (auto-advance), inserts a silence gap between songs and
// issues a one-cycle restart pulse to the newly selected block.
// habilita_mus is a synchronous clock enable for the downstream blocks.
module controle_de_reproducao #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int GAP_CYCLES      = 250000
) (
    input  logic       clock_in,
    input  logic       reset_n,
    input  logic       botao,
    input  logic       auto_avanco,
    input  logic [3:0] fim_musica,
    output logic [1:0] selecao,
    output logic [3:0] habilita_mus,
    output logic [3:0] reinicia_mus,
    output logic       tocando
);

    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [1:0] {
        INICIO   = 2'd0,
        TOCANDO  = 2'd1,
        SILENCIO = 2'd2,
        PARADO   = 2'd3
    } estado_t;

    // One-hot decode of a song index.
    function automatic logic [3:0] onehot(input logic [1:0] idx);
        onehot = 4'b0001 << idx;
    endfunction

    // Button synchronizer and debounce state
    logic          sinc1_r;
    logic          sinc2_r;
    logic          nivel_r;
    logic [DW-1:0] cont_deb_r;
    logic          difere_s;
    logic          cont_cheio_s;
    logic          press_s;

    // Sequencer state
    estado_t       estado_r;
    estado_t       estado_next_s;
    logic [GW-1:0] gap_r;
    logic          pendente_r;
    logic          pendente_next_s;
    logic          primeiro_r;
    logic          avanca_s;
    logic          carrega_gap_s;
    logic          fim_valido_s;
    logic [1:0]    sel_next_s;

    // Next values of the registered outputs
    logic [3:0]    hab_next_s;
    logic [3:0]    rein_next_s;
    logic          toc_next_s;

    // The accepted level flips on the DEBOUNCE_CYCLES-th consecutive
    // differing sample; only a rising flip is reported as a press.
    assign difere_s     = sinc2_r ^ nivel_r;
    assign cont_cheio_s = (cont_deb_r == DW'(DEBOUNCE_CYCLES - 1));
    assign press_s      = difere_s & cont_cheio_s & sinc2_r;

    // Only the end-of-song bit of the selected block matters.
    assign fim_valido_s = fim_musica[selecao];
    assign sel_next_s   = avanca_s ? (selecao + 2'd1) : selecao;

    // Two-flop synchronizer for the asynchronous button input.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            sinc1_r <= 1'b0;
            sinc2_r <= 1'b0;
        end else begin
            sinc1_r <= botao;
            sinc2_r <= sinc1_r;
        end
    end

    // Debounce counter and accepted button level.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            nivel_r    <= 1'b0;
            cont_deb_r <= '0;
        end else if (difere_s) begin
            if (cont_cheio_s) begin
                nivel_r    <= sinc2_r;
                cont_deb_r <= '0;
            end else begin
                nivel_r    <= nivel_r;
                cont_deb_r <= cont_deb_r + DW'(1);
            end
        end else begin
            nivel_r    <= nivel_r;
            cont_deb_r <= '0;
        end
    end

    // State register; primeiro_r holds INICIO one extra cycle after reset so
    // the restart pulse of song 0 is issued on release.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            estado_r   <= INICIO;
            pendente_r <= 1'b0;
            primeiro_r <= 1'b1;
        end else begin
            estado_r   <= estado_next_s;
            pendente_r <= pendente_next_s;
            primeiro_r <= 1'b0;
        end
    end

    // Next-state logic, advance request and gap-reload request.
    always_comb begin
        estado_next_s   = estado_r;
        pendente_next_s = 1'b0;
        avanca_s        = 1'b0;
        carrega_gap_s   = 1'b0;
        case (estado_r)
            INICIO: begin
                // A press here is remembered and served on entry to TOCANDO.
                pendente_next_s = pendente_r | press_s;
                if (primeiro_r) begin
                    estado_next_s = INICIO;
                end else begin
                    estado_next_s = TOCANDO;
                end
            end
            TOCANDO: begin
                if (press_s || pendente_r) begin
                    avanca_s      = 1'b1;
                    carrega_gap_s = 1'b1;
                    estado_next_s = SILENCIO;
                end else if (fim_valido_s) begin
                    if (auto_avanco) begin
                        avanca_s      = 1'b1;
                        carrega_gap_s = 1'b1;
                        estado_next_s = SILENCIO;
                    end else begin
                        estado_next_s = PARADO;
                    end
                end else begin
                    estado_next_s = TOCANDO;
                end
            end
            SILENCIO: begin
                if (press_s) begin
                    avanca_s      = 1'b1;
                    carrega_gap_s = 1'b1;
                    estado_next_s = SILENCIO;
                end else if (gap_r == '0) begin
                    estado_next_s = INICIO;
                end else begin
                    estado_next_s = SILENCIO;
                end
            end
            PARADO: begin
                if (press_s) begin
                    avanca_s      = 1'b1;
                    carrega_gap_s = 1'b1;
                    estado_next_s = SILENCIO;
                end else begin
                    estado_next_s = PARADO;
                end
            end
            default: begin
                estado_next_s = INICIO;
            end
        endcase
    end

    // Song index and silence-gap counter.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            selecao <= 2'd0;
            gap_r   <= '0;
        end else begin
            selecao <= sel_next_s;
            if (carrega_gap_s) begin
                gap_r <= GW'(GAP_CYCLES - 1);
            end else if ((estado_r == SILENCIO) && (gap_r != '0)) begin
                gap_r <= gap_r - GW'(1);
            end else begin
                gap_r <= gap_r;
            end
        end
    end

    // Output decode from the upcoming state so the registered outputs line
    // up with the state they describe.
    always_comb begin
        hab_next_s  = 4'b0000;
        rein_next_s = 4'b0000;
        toc_next_s  = 1'b0;
        if (estado_next_s == TOCANDO) begin
            hab_next_s = onehot(sel_next_s);
            toc_next_s = 1'b1;
        end else if (estado_next_s == INICIO) begin
            rein_next_s = onehot(sel_next_s);
        end else begin
            hab_next_s  = 4'b0000;
            rein_next_s = 4'b0000;
            toc_next_s  = 1'b0;
        end
    end

    // Output registers.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            habilita_mus <= 4'b0000;
            reinicia_mus <= 4'b0000;
            tocando      <= 1'b0;
        end else begin
            habilita_mus <= hab_next_s;
            reinicia_mus <= rein_next_s;
            tocando      <= toc_next_s;
        end
    end

endmodule

// File: tb/tb_controle_de_reproducao.sv
// Scoreboard bench for controle_de_reproducao (DEBOUNCE_CYCLES=4, GAP_CYCLES=3).
// Stimulus pushes every expected change of the output tuple
// {selecao, habilita_mus, reinicia_mus, tocando} together with how long the
// previous tuple must have lasted (0 = any); the monitor pops on each change.
module tb_controle_de_reproducao;

    logic       clock_in = 1'b0;
    logic       reset_n = 1'b0;
    logic       botao = 1'b0;
    logic       auto_avanco = 1'b0;
    logic [3:0] fim_musica = 4'b0000;
    logic [1:0] selecao;
    logic [3:0] habilita_mus;
    logic [3:0] reinicia_mus;
    logic       tocando;

    controle_de_reproducao #(
        .DEBOUNCE_CYCLES(4),
        .GAP_CYCLES     (3)
    ) dut (
        .clock_in    (clock_in),
        .reset_n     (reset_n),
        .botao       (botao),
        .auto_avanco (auto_avanco),
        .fim_musica  (fim_musica),
        .selecao     (selecao),
        .habilita_mus(habilita_mus),
        .reinicia_mus(reinicia_mus),
        .tocando     (tocando)
    );

    always #5 clock_in = ~clock_in;

    typedef struct {
        logic [10:0] tupla;
        int          dur;
    } esperado_t;

    esperado_t   fila[$];
    int          vetores = 0;
    int          erros = 0;
    logic [1:0]  exp_sel = 2'd0;
    logic [10:0] anterior = 11'd0;
    logic [10:0] atual;
    int          retido = 0;
    esperado_t   item;

    function automatic logic [10:0] tup(input logic [1:0] s, input logic [3:0] h,
                                        input logic [3:0] r, input logic t);
        return {s, h, r, t};
    endfunction

    task automatic empurrar(input logic [1:0] s, input logic [3:0] h,
                            input logic [3:0] r, input logic t, input int dur);
        esperado_t e;
        e.tupla = tup(s, h, r, t);
        e.dur   = dur;
        fila.push_back(e);
    endtask

    // Expected sequence for one advance: silence, restart pulse, playing.
    task automatic esperar_avanco();
        logic [1:0] n;
        logic [3:0] oh;
        n  = exp_sel + 2'd1;
        oh = 4'b0001 << n;
        empurrar(n, 4'b0000, 4'b0000, 1'b0, 0);
        empurrar(n, 4'b0000, oh, 1'b0, 3);
        empurrar(n, oh, 4'b0000, 1'b1, 1);
        exp_sel = n;
    endtask

    // Clean press of 10 cycles; fim_coinc is driven in the cycle the
    // debounced press is acted upon (6th edge after the botao rise).
    task automatic pressionar(input logic [3:0] fim_coinc);
        esperar_avanco();
        botao = 1'b1;
        repeat (5) @(negedge clock_in);
        fim_musica = fim_coinc;
        @(negedge clock_in);
        fim_musica = 4'b0000;
        repeat (4) @(negedge clock_in);
        botao = 1'b0;
        repeat (12) @(negedge clock_in);
    endtask

    // Monitor: invariants every cycle, scoreboard pop on each output change.
    initial begin
        forever begin
            @(negedge clock_in);
            atual = {selecao, habilita_mus, reinicia_mus, tocando};
            vetores++;
            if (($countones(habilita_mus) > 1) ||
                ((habilita_mus != 4'b0000) && (reinicia_mus != 4'b0000))) begin
                erros++;
                $display("FAIL invariante: habilita_mus=%b reinicia_mus=%b t=%0t",
                         habilita_mus, reinicia_mus, $time);
            end
            if (atual !== anterior) begin
                vetores++;
                if (fila.size() == 0) begin
                    erros++;
                    $display("FAIL mudanca_inesperada: got sel=%b hab=%b rein=%b toc=%b, required no change t=%0t",
                             selecao, habilita_mus, reinicia_mus, tocando, $time);
                end else begin
                    item = fila.pop_front();
                    if (atual !== item.tupla) begin
                        erros++;
                        $display("FAIL tupla: got {sel,hab,rein,toc}=%b required %b t=%0t",
                                 atual, item.tupla, $time);
                    end
                    if (item.dur != 0) begin
                        vetores++;
                        if (retido != item.dur) begin
                            erros++;
                            $display("FAIL duracao: previous tuple held %0d cycles, required %0d t=%0t",
                                     retido, item.dur, $time);
                        end
                    end
                end
                anterior = atual;
                retido   = 1;
            end else begin
                retido++;
            end
        end
    end

    // Stimulus
    initial begin
        #1;
        vetores++;
        if ({selecao, habilita_mus, reinicia_mus, tocando} !== 11'd0) begin
            erros++;
            $display("FAIL reset: got %b required 0", {selecao, habilita_mus, reinicia_mus, tocando});
        end
        repeat (3) @(negedge clock_in);

        // 1: release reset -> restart song 0, then play it
        empurrar(2'd0, 4'b0000, 4'b0001, 1'b0, 0);
        empurrar(2'd0, 4'b0001, 4'b0000, 1'b1, 1);
        reset_n = 1'b1;
        repeat (4) @(negedge clock_in);

        // 2: one clean press -> song 1
        pressionar(4'b0000);

        // 3: bouncing button never accepted
        for (int i = 0; i < 6; i++) begin
            botao = ~botao;
            repeat (2) @(negedge clock_in);
        end
        botao = 1'b0;
        repeat (10) @(negedge clock_in);

        // 6a: press coincident with valid fim at song 1 -> single advance to 2
        auto_avanco = 1'b1;
        pressionar(4'b0010);

        // 5: auto_avanco=0, fim of song 2 -> PARADO; later press -> song 3
        auto_avanco = 1'b0;
        empurrar(2'd2, 4'b0000, 4'b0000, 1'b0, 0);
        fim_musica = 4'b0100;
        @(negedge clock_in);
        fim_musica = 4'b0000;
        repeat (4) @(negedge clock_in);
        pressionar(4'b0000);

        // 4: auto_avanco=1 at song 3: foreign fim ignored, own fim wraps to 0
        auto_avanco = 1'b1;
        fim_musica = 4'b0010;
        @(negedge clock_in);
        fim_musica = 4'b0000;
        repeat (4) @(negedge clock_in);
        esperar_avanco();
        fim_musica = 4'b1000;
        @(negedge clock_in);
        fim_musica = 4'b0000;
        repeat (10) @(negedge clock_in);

        // 6b: reset mid-silence -> immediate zeros, then restart from song 0
        empurrar(2'd1, 4'b0000, 4'b0000, 1'b0, 0);
        botao = 1'b1;
        repeat (7) @(negedge clock_in);
        #2;
        reset_n = 1'b0;
        #1;
        vetores++;
        if ({selecao, habilita_mus, reinicia_mus, tocando} !== 11'd0) begin
            erros++;
            $display("FAIL reset_assincrono: got %b required 0",
                     {selecao, habilita_mus, reinicia_mus, tocando});
        end
        empurrar(2'd0, 4'b0000, 4'b0000, 1'b0, 0);
        botao   = 1'b0;
        exp_sel = 2'd0;
        repeat (2) @(negedge clock_in);
        empurrar(2'd0, 4'b0000, 4'b0001, 1'b0, 0);
        empurrar(2'd0, 4'b0001, 4'b0000, 1'b1, 1);
        reset_n = 1'b1;
        repeat (8) @(negedge clock_in);

        vetores++;
        if (fila.size() != 0) begin
            erros++;
            $display("FAIL fila_pendente: %0d expected changes never seen, required 0", fila.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vetores, erros);
        $finish;
    end

endmodule
